// File: rtl/stats_stream_scheduler.sv
// Round-robin front end that time-shares one statistics engine between
// NUM_SRC valid/ready producers, tagging beats and clearing on owner change.
module stats_stream_scheduler #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 64,
  parameter int BURST   = 16,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic [DATA_W-1:0]         eng_data,
  output logic                      eng_valid,
  input  logic                      eng_ready,
  output logic [SRC_W-1:0]          eng_src,
  output logic                      eng_clear,
  output logic                      busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CLEAR  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  localparam logic [7:0]       LAST_BEAT = 8'(BURST - 1);
  localparam logic [SRC_W-1:0] LAST_SRC  = SRC_W'(NUM_SRC - 1);

  logic [1:0]       state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [SRC_W-1:0] last_grant_q, last_grant_d;
  logic [SRC_W-1:0] owner_q, owner_d;
  logic             owner_vld_q, owner_vld_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;

  logic             arb_hit;
  logic [SRC_W-1:0] arb_idx;
  logic [SRC_W-1:0] cand;
  logic [DATA_W-1:0] mux_data;
  logic             mux_valid;

  // Round-robin search: first requester strictly after last_grant.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = last_grant_q;
    cand    = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand = SRC_W'((int'(last_grant_q) + i) % NUM_SRC);
      if (!arb_hit && src_valid[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  // Select the granted source's beat and valid.
  always_comb begin
    mux_data  = '0;
    mux_valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == SRC_W'(i)) begin
        mux_data  = src_data[i*DATA_W +: DATA_W];
        mux_valid = src_valid[i];
      end
    end
  end

  // Grant FSM: pick, optionally clear the engine, then stream a burst.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    owner_vld_d  = owner_vld_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      S_IDLE: begin
        beat_cnt_d = '0;
        if (arb_hit) begin
          grant_d      = arb_idx;
          last_grant_d = arb_idx;
          if (owner_vld_q && (arb_idx == owner_q)) begin
            state_d = S_STREAM;
          end else begin
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        owner_d     = grant_q;
        owner_vld_d = 1'b1;
        state_d     = S_STREAM;
      end
      S_STREAM: begin
        if (!mux_valid) begin
          state_d = S_IDLE;
        end else if (eng_ready) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset makes source 0 the first winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_SRC;
      owner_q      <= '0;
      owner_vld_q  <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      owner_vld_q  <= owner_vld_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Outputs; forced quiet while reset is asserted so no beat slips through.
  always_comb begin
    src_ready = '0;
    eng_data  = '0;
    eng_valid = 1'b0;
    eng_src   = '0;
    eng_clear = 1'b0;
    busy      = 1'b0;
    if (!reset) begin
      eng_clear = (state_q == S_CLEAR);
      busy      = (state_q != S_IDLE);
      eng_src   = owner_vld_q ? owner_q : '0;
      if (state_q == S_STREAM) begin
        eng_data  = mux_data;
        eng_valid = mux_valid;
        for (int i = 0; i < NUM_SRC; i++) begin
          src_ready[i] = eng_ready && (grant_q == SRC_W'(i));
        end
      end
    end
  end

endmodule
